// File: rtl/hqm_rcfwl_gclk_usync_pkg.sv
// -----------------------------------------------------------------------------
// hqm_rcfwl_gclk_usync_pkg
// Shared types and helpers for the USYNC generator in the clock distribution
// unit.
//   usync_state_t   : FSM encoding (IDLE, RUN, GAP)
//   usync_params_ok : parameter legality check used at elaboration
// -----------------------------------------------------------------------------
package hqm_rcfwl_gclk_usync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } usync_state_t;

  // PERIOD >= 2, 1 <= USYNC_HIGH <= PERIOD-1 and SYNC_STAGES >= 2.
  function automatic bit usync_params_ok(input int period,
                                         input int high,
                                         input int stages);
    return (period >= 2) && (high >= 1) && (high <= period - 1) &&
           (stages >= 2);
  endfunction

endpackage

// File: rtl/hqm_rcfwl_gclk_usync_sync.sv
// -----------------------------------------------------------------------------
// hqm_rcfwl_gclk_usync_sync
// Parameterized-depth single-bit synchronizer. Every flop resets to 0.
//   clk  : destination clock
//   rst  : asynchronous active-high reset
//   i_d  : asynchronous input bit
//   o_q  : synchronized output (STAGES clock edges of latency)
// -----------------------------------------------------------------------------
module hqm_rcfwl_gclk_usync_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/hqm_rcfwl_gclk_pccdu_usync_gen.sv
// -----------------------------------------------------------------------------
// hqm_rcfwl_gclk_pccdu_usync_gen
// Periodic USYNC generator on the primary grid clock, plus the single-cycle
// active-low reset pulse that restarts every DOP divider phase-aligned.
//   clk       : primary grid clock
//   rst       : asynchronous active-high reset
//   usync_en  : asynchronous enable (synchronized internally)
//   realign   : synchronous single-cycle request to restart alignment
//   usync     : USYNC alignment signal, high for USYNC_HIGH of every PERIOD
//   div_rst_b : divider reset, low for one cycle after each USYNC rise
//   aligned   : dividers have seen a reset pulse since the last (re)start
//   phase     : position within the USYNC period
// All outputs are registered.
// -----------------------------------------------------------------------------
module hqm_rcfwl_gclk_pccdu_usync_gen
  import hqm_rcfwl_gclk_usync_pkg::*;
#(
  parameter  int PERIOD      = 12,
  parameter  int USYNC_HIGH  = 1,
  parameter  int SYNC_STAGES = 2,
  localparam int CNTW        = (PERIOD < 2) ? 1 : $clog2(PERIOD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            usync_en,
  input  logic            realign,
  output logic            usync,
  output logic            div_rst_b,
  output logic            aligned,
  output logic [CNTW-1:0] phase
);

  if (!usync_params_ok(PERIOD, USYNC_HIGH, SYNC_STAGES)) begin : g_bad_params
    $error("hqm_rcfwl_gclk_pccdu_usync_gen: illegal PERIOD/USYNC_HIGH/SYNC_STAGES");
  end

  localparam logic [CNTW-1:0] LAST_PHASE = CNTW'(PERIOD - 1);
  localparam logic [CNTW-1:0] HIGH_LIM   = CNTW'(USYNC_HIGH);

  logic            w_en_s;
  usync_state_t    r_state;
  usync_state_t    w_state_nxt;
  logic [CNTW-1:0] r_phase;
  logic [CNTW-1:0] w_phase_nxt;
  logic            r_usync;
  logic            r_usync_q;
  logic            r_div_rst_b;
  logic            r_aligned;

  hqm_rcfwl_gclk_usync_sync #(
    .STAGES (SYNC_STAGES)
  ) u_en_sync (
    .clk (clk),
    .rst (rst),
    .i_d (usync_en),
    .o_q (w_en_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase only advances while staying in RUN; every entry into RUN (from IDLE
  // or GAP) starts at phase 0 so the first RUN cycle always carries USYNC high.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = '0;
    case (r_state)
      IDLE: begin
        if (w_en_s) w_state_nxt = RUN;
      end
      RUN: begin
        if (!w_en_s) begin
          w_state_nxt = IDLE;
        end else if (realign) begin
          w_state_nxt = GAP;
        end else begin
          w_phase_nxt = (r_phase == LAST_PHASE) ? '0 : r_phase + CNTW'(1);
        end
      end
      GAP: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they line up with the state
  // register. A pending divider pulse is dropped when falling back to IDLE,
  // and 'aligned' only sets from a pulse issued during the current RUN span,
  // never from one launched just before a GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_usync     <= 1'b0;
      r_usync_q   <= 1'b0;
      r_div_rst_b <= 1'b1;
      r_aligned   <= 1'b0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_usync     <= (w_state_nxt == RUN) && (w_phase_nxt < HIGH_LIM);
      r_usync_q   <= r_usync;
      r_div_rst_b <= (w_state_nxt == IDLE) ? 1'b1 : ~(r_usync & ~r_usync_q);
      r_aligned   <= (w_state_nxt != RUN) ? 1'b0 :
                     (r_aligned | ((r_state == RUN) & ~r_div_rst_b));
    end
  end

  assign usync     = r_usync;
  assign div_rst_b = r_div_rst_b;
  assign aligned   = r_aligned;
  assign phase     = r_phase;

endmodule

// File: tb/tb_hqm_rcfwl_gclk_pccdu_usync_gen.sv
module tb_hqm_rcfwl_gclk_pccdu_usync_gen;

  logic clk = 1'b0;
  logic rst;

  // Narrow configuration: PERIOD=12, USYNC_HIGH=1
  logic       n_en, n_re, n_usync, n_drb, n_al;
  logic [3:0] n_ph;
  // Wide configuration: PERIOD=6, USYNC_HIGH=3
  logic       w_en, w_re, w_usync, w_drb, w_al;
  logic [2:0] w_ph;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hqm_rcfwl_gclk_pccdu_usync_gen #(
    .PERIOD(12), .USYNC_HIGH(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .usync_en(n_en), .realign(n_re),
    .usync(n_usync), .div_rst_b(n_drb), .aligned(n_al), .phase(n_ph)
  );

  hqm_rcfwl_gclk_pccdu_usync_gen #(
    .PERIOD(6), .USYNC_HIGH(3), .SYNC_STAGES(2)
  ) dut_w (
    .clk(clk), .rst(rst), .usync_en(w_en), .realign(w_re),
    .usync(w_usync), .div_rst_b(w_drb), .aligned(w_al), .phase(w_ph)
  );

  // DOP divider model, DIVISOR=3, restarted by div_rst_b of the narrow DUT.
  logic [1:0] dv_cnt = 2'd0;
  logic       dv_clk = 1'b0;
  always @(posedge clk) begin
    if (!n_drb) begin
      dv_cnt <= 2'd0;
      dv_clk <= 1'b0;
    end else begin
      dv_cnt <= (dv_cnt == 2'd2) ? 2'd0 : dv_cnt + 2'd1;
      dv_clk <= (dv_cnt == 2'd0);
    end
  end

  typedef struct {
    logic       en;
    logic       re;
    logic       u;
    logic       d;
    logic       a;
    logic [3:0] p;
  } vec_t;

  vec_t tv [1:26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic setv(input int i, input logic en, input logic re, input logic u,
                      input logic d, input logic a, input logic [3:0] p);
    tv[i].en = en; tv[i].re = re; tv[i].u = u;
    tv[i].d  = d;  tv[i].a  = a;  tv[i].p = p;
  endtask

  initial begin
    int cnt;
    bit hit;

    // Vectors for the narrow DUT, one entry per clock edge after reset release.
    // usync_en rises before edge 1; en_s = 1 at edge 2 (E0).
    setv(1, 1, 0, 0, 1, 0, 4'd0);
    setv(2, 1, 0, 0, 1, 0, 4'd0);
    setv(3, 1, 0, 1, 1, 0, 4'd0);   // E0+1: first USYNC
    setv(4, 1, 0, 0, 0, 0, 4'd1);   // divider pulse
    setv(5, 1, 0, 0, 1, 1, 4'd2);   // aligned
    for (int i = 6; i <= 14; i++) setv(i, 1, 0, 0, 1, 1, 4'(i - 3));
    setv(15, 1, 0, 1, 1, 1, 4'd0);  // E0+1+PERIOD
    setv(16, 1, 0, 0, 0, 1, 4'd1);
    setv(17, 1, 0, 0, 1, 1, 4'd2);
    setv(18, 1, 1, 0, 1, 0, 4'd0);  // realign -> GAP
    setv(19, 1, 0, 1, 1, 0, 4'd0);  // RUN, fresh USYNC
    setv(20, 1, 0, 0, 0, 0, 4'd1);
    setv(21, 1, 0, 0, 1, 1, 4'd2);
    setv(22, 0, 0, 0, 1, 1, 4'd3);  // usync_en drops
    setv(23, 0, 0, 0, 1, 1, 4'd4);
    setv(24, 0, 1, 0, 1, 0, 4'd0);  // en_s low together with realign -> IDLE
    setv(25, 0, 0, 0, 1, 0, 4'd0);
    setv(26, 0, 0, 0, 1, 0, 4'd0);

    rst = 1'b1;
    n_en = 0; n_re = 0; w_en = 0; w_re = 0;
    tick();
    tick();
    chk("rst_usync",   n_usync, 0);
    chk("rst_drb",     n_drb,   1);
    chk("rst_aligned", n_al,    0);
    chk("rst_phase",   n_ph,    0);
    chk("rst_w_usync", w_usync, 0);
    chk("rst_w_drb",   w_drb,   1);
    rst = 1'b0;

    for (int i = 1; i <= 26; i++) begin
      n_en = tv[i].en;
      n_re = tv[i].re;
      tick();
      chk($sformatf("vec%0d_usync", i),   n_usync, tv[i].u);
      chk($sformatf("vec%0d_drb", i),     n_drb,   tv[i].d);
      chk($sformatf("vec%0d_aligned", i), n_al,    tv[i].a);
      chk($sformatf("vec%0d_phase", i),   n_ph,    tv[i].p);
    end
    n_re = 0;

    // Wide pulse: PERIOD=6, USYNC_HIGH=3.
    w_en = 1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (w_usync) hit = 1;
    end
    chk("wide_first_usync_seen", hit, 1);
    cnt = 0;
    for (int c = 0; c < 18; c++) begin
      chk($sformatf("wide_c%0d_phase", c), w_ph, c % 6);
      chk($sformatf("wide_c%0d_usync", c), w_usync, ((c % 6) < 3) ? 1 : 0);
      if (!w_drb) cnt++;
      tick();
    end
    chk("wide_pulses_in_3_periods", cnt, 3);

    // Realign at phase 1 while USYNC is high.
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (w_ph == 3'd1 && w_usync && w_al) hit = 1;
      else tick();
    end
    chk("wide_reach_phase1", hit, 1);
    w_re = 1;
    tick();
    w_re = 0;
    chk("gap_usync",   w_usync, 0);
    chk("gap_aligned", w_al,    0);
    chk("gap_phase",   w_ph,    0);
    tick();
    chk("ra1_usync",   w_usync, 1);
    chk("ra1_phase",   w_ph,    0);
    chk("ra1_drb",     w_drb,   1);
    tick();
    chk("ra2_drb",     w_drb,   0);
    chk("ra2_phase",   w_ph,    1);
    chk("ra2_aligned", w_al,    0);
    tick();
    chk("ra3_drb",     w_drb,   1);
    chk("ra3_aligned", w_al,    1);

    // Asynchronous reset mid-period on the narrow DUT.
    n_en = 1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (n_ph == 4'd7 && n_al) hit = 1;
    end
    chk("reach_phase7_aligned", hit, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_usync",   n_usync, 0);
    chk("arst_drb",     n_drb,   1);
    chk("arst_aligned", n_al,    0);
    chk("arst_phase",   n_ph,    0);
    tick();
    rst = 1'b0;
    cnt = 0;
    hit = 0;
    for (int i = 1; i <= 10 && !hit; i++) begin
      tick();
      if (n_usync) begin
        hit = 1;
        cnt = i;
      end
    end
    chk("post_rst_usync_edges", cnt, 3);

    // Divider DIVISOR=3 phase consistency across USYNC periods.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (!n_drb) hit = 1;
    end
    chk("div_pulse_seen", hit, 1);
    for (int k = 1; k <= 36; k++) begin
      tick();
      chk($sformatf("div_k%0d_clk", k), dv_clk, ((k % 3) == 2) ? 1 : 0);
      chk($sformatf("div_k%0d_phase", k), n_ph, (1 + k) % 12);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
